qos_packet_scheduler: RTL and testbench

//  Packet-level grant controller for the QoS stream arbiter datapath.
//  - Picks one of STREAM_COUNT input streams by QoS, with round-robin tie-break among equal QoS.
//  - Holds the grant for the whole packet, until the last beat is accepted.
//  - Drives the arbiter mux select, per-stream ready and output valid.
//  - Sits between the input streams and the data/QoS muxes; carries no data bits itself.

---
 rtl/qos_packet_scheduler.sv | 165 ++++++++++++++++
 tb/tb_qos_packet_scheduler.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qos_packet_scheduler.sv
// qos_packet_scheduler: packet-level grant controller for a QoS stream arbiter.
// Picks the valid stream with the highest effective QoS. Equal QoS resolves
// round-robin from rr_ptr. The grant is held until the granted stream's last
// beat is accepted, and one idle cycle always follows each packet.
// Optional feature: define QOS_AGING_EN to add per-stream age counters. A stream
// whose age has saturated competes with all-ones QoS.
module qos_packet_scheduler #(
  parameter int unsigned T_QOS__WIDTH = 4,
  parameter int unsigned STREAM_COUNT = 2,
  parameter int unsigned T_ID___WIDTH = $clog2(STREAM_COUNT),
  parameter int unsigned AGE_WIDTH    = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [T_QOS__WIDTH-1:0] s_qos_i [STREAM_COUNT],
  input  logic [STREAM_COUNT-1:0] s_valid_i,
  input  logic [STREAM_COUNT-1:0] s_last_i,
  input  logic                    m_ready_i,
  output logic [STREAM_COUNT-1:0] s_ready_o,
  output logic                    m_valid_o,
  output logic [T_ID___WIDTH-1:0] m_id_o,
  output logic                    m_last_o,
  output logic                    busy_o
);

  // Reject configurations the round-robin and aging logic cannot support.
  if (STREAM_COUNT < 2 || AGE_WIDTH < 1) begin : g_param_err
    $error("qos_packet_scheduler: need STREAM_COUNT >= 2 and AGE_WIDTH >= 1");
  end

  typedef enum logic {StIdle, StBusy} state_e;

  state_e                  state_q, state_d;
  logic [T_ID___WIDTH-1:0] m_id_q, m_id_d;
  logic [T_ID___WIDTH-1:0] rr_ptr_q, rr_ptr_d;

  logic [T_QOS__WIDTH-1:0] eff_qos [STREAM_COUNT];
  logic [T_QOS__WIDTH-1:0] max_qos;
  logic [T_ID___WIDTH-1:0] winner;
  logic [T_ID___WIDTH-1:0] scan_idx;
  logic                    found;
  logic                    beat_xfer;
  logic                    pkt_end;

  // A beat moves only on the granted stream while locked.
  assign beat_xfer = (state_q == StBusy) & s_valid_i[m_id_q] & m_ready_i;
  assign pkt_end   = beat_xfer & s_last_i[m_id_q];

`ifdef QOS_AGING_EN
  logic [AGE_WIDTH-1:0] age_q [STREAM_COUNT];
  logic [AGE_WIDTH-1:0] age_d [STREAM_COUNT];

  // A saturated age promotes the stream to the top QoS level.
  always_comb begin
    for (int i = 0; i < STREAM_COUNT; i++) begin
      eff_qos[i] = (&age_q[i]) ? '1 : s_qos_i[i];
    end
  end

  // At packet end: winner's age clears, other waiting streams age (saturating).
  always_comb begin
    for (int i = 0; i < STREAM_COUNT; i++) begin
      age_d[i] = age_q[i];
      if (pkt_end) begin
        if (T_ID___WIDTH'(i) == m_id_q) begin
          age_d[i] = '0;
        end else if (s_valid_i[i] && !(&age_q[i])) begin
          age_d[i] = age_q[i] + 1'b1;
        end
      end
    end
  end

  // Age registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STREAM_COUNT; i++) begin
        age_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < STREAM_COUNT; i++) begin
        age_q[i] <= age_d[i];
      end
    end
  end
`else
  // Without aging the effective QoS is the raw request QoS.
  always_comb begin
    for (int i = 0; i < STREAM_COUNT; i++) begin
      eff_qos[i] = s_qos_i[i];
    end
  end
`endif

  // Winner: highest effective QoS among valid streams, first one at or after rr_ptr.
  always_comb begin
    max_qos  = '0;
    winner   = rr_ptr_q;
    scan_idx = rr_ptr_q;
    found    = 1'b0;
    for (int i = 0; i < STREAM_COUNT; i++) begin
      if (s_valid_i[i] && (eff_qos[i] > max_qos)) begin
        max_qos = eff_qos[i];
      end
    end
    for (int unsigned k = 0; k < STREAM_COUNT; k++) begin
      scan_idx = T_ID___WIDTH'((32'(rr_ptr_q) + k) % STREAM_COUNT);
      if (!found && s_valid_i[scan_idx] && (eff_qos[scan_idx] == max_qos)) begin
        winner = scan_idx;
        found  = 1'b1;
      end
    end
  end

  // FSM next state: grant in IDLE, release on the accepted last beat.
  always_comb begin
    state_d  = state_q;
    m_id_d   = m_id_q;
    rr_ptr_d = rr_ptr_q;
    unique case (state_q)
      StIdle: begin
        if (|s_valid_i) begin
          m_id_d  = winner;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (pkt_end) begin
          state_d  = StIdle;
          rr_ptr_d = (m_id_q == T_ID___WIDTH'(STREAM_COUNT - 1)) ? '0 : m_id_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM state, grant index and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      m_id_q   <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      m_id_q   <= m_id_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Outputs decoded from the locked grant; all zero outside BUSY.
  always_comb begin
    s_ready_o = '0;
    m_valid_o = 1'b0;
    m_last_o  = 1'b0;
    if (state_q == StBusy) begin
      s_ready_o[m_id_q] = m_ready_i;
      m_valid_o         = s_valid_i[m_id_q];
      m_last_o          = s_valid_i[m_id_q] & s_last_i[m_id_q];
    end
  end

  assign m_id_o = m_id_q;
  assign busy_o = (state_q == StBusy);

endmodule

// File: tb/tb_qos_packet_scheduler.sv
// Self-checking bench for qos_packet_scheduler (2 streams, 4-bit QoS).
// A per-cycle vector table covers basic arbitration, ready back-pressure and
// round-robin wrap. A grant scoreboard covers back-to-back packet streams.
// Hand-written sequences cover grant lock, a mid-packet reset and starvation or aging.
module tb_qos_packet_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] s_qos [2];
  logic [1:0] s_valid;
  logic [1:0] s_last;
  logic       m_ready;
  logic [1:0] s_ready;
  logic       m_valid;
  logic [0:0] m_id;
  logic       m_last;
  logic       busy;

  int checks   = 0;
  int failures = 0;
  int exp_q[$];

  typedef struct {
    logic [1:0] valid;
    logic [3:0] q0;
    logic [3:0] q1;
    logic [1:0] last;
    logic       ready;
    logic       e_busy;
    logic       e_mvalid;
    logic       e_id;
    logic [1:0] e_sready;
    logic       e_mlast;
  } vec_t;

  vec_t vecs[$];

  qos_packet_scheduler #(
    .T_QOS__WIDTH(4),
    .STREAM_COUNT(2),
    .T_ID___WIDTH(1),
    .AGE_WIDTH   (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .s_qos_i  (s_qos),
    .s_valid_i(s_valid),
    .s_last_i (s_last),
    .m_ready_i(m_ready),
    .s_ready_o(s_ready),
    .m_valid_o(m_valid),
    .m_id_o   (m_id),
    .m_last_o (m_last),
    .busy_o   (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [1:0] v, input int q0, input int q1, input logic [1:0] l,
                     input logic r, input logic eb, input logic emv, input logic eid,
                     input logic [1:0] esr, input logic eml);
    vec_t x;
    x.valid = v;  x.q0 = 4'(q0);  x.q1 = 4'(q1);  x.last = l;  x.ready = r;
    x.e_busy = eb;  x.e_mvalid = emv;  x.e_id = eid;  x.e_sready = esr;  x.e_mlast = eml;
    vecs.push_back(x);
  endtask

  task automatic drive(input logic [1:0] v, input logic [1:0] l, input logic r);
    s_valid = v;
    s_last  = l;
    m_ready = r;
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    drive(2'b00, 2'b00, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Both streams always valid, sending packets of fixed length; each completed
  // packet is checked against the next expected grant and its length.
  task automatic run_sources(input int npk, input int budget, input int l0, input int l1);
    int beat [2];
    int len  [2];
    int done;
    int pkt_beats;
    int e;
    logic [1:0] xfer;
    beat[0] = 0;  beat[1] = 0;
    len[0]  = l0; len[1]  = l1;
    done = 0;
    pkt_beats = 0;
    for (int c = 0; c < budget && done < npk; c++) begin
      s_valid = 2'b11;
      m_ready = 1'b1;
      for (int i = 0; i < 2; i++) s_last[i] = (beat[i] == len[i] - 1);
      @(negedge clk);
      xfer = s_valid & s_ready;
      if (m_valid && m_ready) begin
        if (m_last) begin
          if (exp_q.size() == 0) begin
            check("sb_unexpected_packet", 32'(exp_q.size()), 32'd1);
          end else begin
            e = exp_q.pop_front();
            check($sformatf("sb_grant[%0d]", done), 32'(m_id), 32'(e));
            check($sformatf("sb_len[%0d]", done), 32'(pkt_beats + 1), 32'(len[e]));
          end
          done++;
          pkt_beats = 0;
        end else begin
          pkt_beats++;
        end
      end
      next_cycle();
      for (int i = 0; i < 2; i++) begin
        if (xfer[i]) beat[i] = (beat[i] == len[i] - 1) ? 0 : beat[i] + 1;
      end
    end
    check("sb_drain", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    drive(2'b00, 2'b00, 1'b0);
  endtask

  initial begin
    s_qos[0] = '0;
    s_qos[1] = '0;
    rst = 1'b1;
    drive(2'b11, 2'b11, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mvalid", 32'(m_valid), 32'd0);
    check("rst_sready", 32'(s_ready), 32'd0);
    check("rst_mlast", 32'(m_last), 32'd0);
    check("rst_id", 32'(m_id), 32'd0);
    drive(2'b00, 2'b00, 1'b0);
    rst = 1'b0;

    // valid  q0 q1 last  rdy | busy mv id sready mlast
    // QoS 2 vs 5, 3-beat packets: stream 1 first, one idle cycle, then stream 0.
    add(2'b11, 2, 5, 2'b00, 1,  0, 0, 0, 2'b00, 0);
    add(2'b11, 2, 5, 2'b00, 1,  1, 1, 1, 2'b10, 0);
    add(2'b11, 2, 5, 2'b00, 1,  1, 1, 1, 2'b10, 0);
    add(2'b11, 2, 5, 2'b10, 1,  1, 1, 1, 2'b10, 1);
    add(2'b01, 2, 5, 2'b00, 1,  0, 0, 1, 2'b00, 0);
    add(2'b01, 2, 5, 2'b00, 1,  1, 1, 0, 2'b01, 0);
    add(2'b01, 2, 5, 2'b00, 1,  1, 1, 0, 2'b01, 0);
    add(2'b01, 2, 5, 2'b01, 1,  1, 1, 0, 2'b01, 1);
    add(2'b00, 2, 5, 2'b00, 1,  0, 0, 0, 2'b00, 0);
    add(2'b00, 2, 5, 2'b00, 1,  0, 0, 0, 2'b00, 0);
    // 4-beat packet with toggling ready: eight BUSY cycles.
    add(2'b01, 7, 7, 2'b00, 0,  0, 0, 0, 2'b00, 0);
    add(2'b01, 7, 7, 2'b00, 0,  1, 1, 0, 2'b00, 0);
    add(2'b01, 7, 7, 2'b00, 1,  1, 1, 0, 2'b01, 0);
    add(2'b01, 7, 7, 2'b00, 0,  1, 1, 0, 2'b00, 0);
    add(2'b01, 7, 7, 2'b00, 1,  1, 1, 0, 2'b01, 0);
    add(2'b01, 7, 7, 2'b00, 0,  1, 1, 0, 2'b00, 0);
    add(2'b01, 7, 7, 2'b00, 1,  1, 1, 0, 2'b01, 0);
    add(2'b01, 7, 7, 2'b01, 0,  1, 1, 0, 2'b00, 1);
    add(2'b01, 7, 7, 2'b01, 1,  1, 1, 0, 2'b01, 1);
    add(2'b00, 7, 7, 2'b00, 1,  0, 0, 0, 2'b00, 0);
    // Equal QoS with rr_ptr=1: stream 1 wins, single-beat packet, pointer wraps to 0.
    add(2'b11, 3, 3, 2'b00, 1,  0, 0, 0, 2'b00, 0);
    add(2'b11, 3, 3, 2'b10, 1,  1, 1, 1, 2'b10, 1);
    add(2'b11, 3, 3, 2'b00, 1,  0, 0, 1, 2'b00, 0);
    add(2'b11, 3, 3, 2'b01, 0,  1, 1, 0, 2'b00, 1);
    add(2'b11, 3, 3, 2'b01, 1,  1, 1, 0, 2'b01, 1);
    add(2'b00, 3, 3, 2'b00, 1,  0, 0, 0, 2'b00, 0);

    for (int k = 0; k < vecs.size(); k++) begin
      s_valid  = vecs[k].valid;
      s_qos[0] = vecs[k].q0;
      s_qos[1] = vecs[k].q1;
      s_last   = vecs[k].last;
      m_ready  = vecs[k].ready;
      @(negedge clk);
      check($sformatf("vec[%0d].busy", k), 32'(busy), 32'(vecs[k].e_busy));
      check($sformatf("vec[%0d].m_valid", k), 32'(m_valid), 32'(vecs[k].e_mvalid));
      check($sformatf("vec[%0d].m_id", k), 32'(m_id), 32'(vecs[k].e_id));
      check($sformatf("vec[%0d].s_ready", k), 32'(s_ready), 32'(vecs[k].e_sready));
      check($sformatf("vec[%0d].m_last", k), 32'(m_last), 32'(vecs[k].e_mlast));
      next_cycle();
    end

    // Equal QoS, back-to-back 2-beat packets: grants alternate starting at 0.
    do_reset();
    s_qos[0] = 4'd3;
    s_qos[1] = 4'd3;
    exp_q = '{0, 1, 0, 1};
    run_sources(4, 40, 2, 2);

    // Grant lock: stream 0 valid gap while stream 1 requests at QoS 15.
    do_reset();
    s_qos[0] = 4'd2;
    s_qos[1] = 4'd15;
    drive(2'b01, 2'b00, 1'b1);
    @(negedge clk);
    check("lock_idle_busy", 32'(busy), 32'd0);
    next_cycle();
    @(negedge clk);
    check("lock_grant0", 32'(m_id), 32'd0);
    check("lock_mvalid_first", 32'(m_valid), 32'd1);
    next_cycle();
    for (int g = 0; g < 2; g++) begin
      drive(2'b10, 2'b00, 1'b1);
      @(negedge clk);
      check($sformatf("lock_gap%0d_id", g), 32'(m_id), 32'd0);
      check($sformatf("lock_gap%0d_mvalid", g), 32'(m_valid), 32'd0);
      check($sformatf("lock_gap%0d_busy", g), 32'(busy), 32'd1);
      check($sformatf("lock_gap%0d_sready", g), 32'(s_ready), 32'b01);
      next_cycle();
    end
    drive(2'b11, 2'b01, 1'b1);
    @(negedge clk);
    check("lock_last_id", 32'(m_id), 32'd0);
    check("lock_last_mlast", 32'(m_last), 32'd1);
    next_cycle();
    drive(2'b10, 2'b00, 1'b1);
    @(negedge clk);
    check("lock_gap_after_last", 32'(busy), 32'd0);
    next_cycle();
    drive(2'b10, 2'b10, 1'b1);
    @(negedge clk);
    check("lock_then_grant1", 32'(m_id), 32'd1);
    check("lock_then_busy", 32'(busy), 32'd1);
    next_cycle();

    // Mid-packet reset: advance rr_ptr to 1, lock stream 1, then reset.
    drive(2'b01, 2'b01, 1'b1);
    next_cycle();
    @(negedge clk);
    check("pre_rst_single_beat", 32'(m_last), 32'd1);
    next_cycle();
    drive(2'b10, 2'b00, 1'b1);
    next_cycle();
    @(negedge clk);
    check("pre_rst_busy", 32'(busy), 32'd1);
    check("pre_rst_id", 32'(m_id), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_sready", 32'(s_ready), 32'd0);
    check("midrst_mvalid", 32'(m_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    next_cycle();
    rst = 1'b0;
    s_qos[0] = 4'd3;
    s_qos[1] = 4'd3;
    drive(2'b11, 2'b00, 1'b1);
    next_cycle();
    @(negedge clk);
    check("postrst_busy", 32'(busy), 32'd1);
    check("postrst_rr_grant0", 32'(m_id), 32'd0);
    next_cycle();

    // QoS 0 vs 15, both always valid.
    do_reset();
    s_qos[0] = 4'd0;
    s_qos[1] = 4'd15;
`ifdef QOS_AGING_EN
    exp_q = '{1, 1, 1, 0, 1, 1, 1, 0};
`else
    exp_q = '{1, 1, 1, 1, 1, 1, 1, 1};
`endif
    run_sources(8, 80, 2, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
